// File: rtl/countdown_timer_bank_pkg.sv
// Shared definitions for the countdown timer bank.
// Channel state encodings, default rates and a sizing helper.
package countdown_timer_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

    localparam int CLK_HZ_DEF  = 100_000_000;
    localparam int TICK_HZ_DEF = 1;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_bank_tick.sv
// Free-running prescaler producing one registered tick every DIV cycles.
// The tick is high exactly while the counter sits at DIV-1.
module tick_prescaler
    import countdown_timer_bank_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int TICK_HZ = TICK_HZ_DEF
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE  = PW'(DIV - 2);

    logic [PW-1:0] cnt;

    // tick is registered one cycle early so it coincides with cnt == LAST
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == PRE);
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bank.sv
// N-channel countdown timer bank sharing one prescaled tick.
// Each channel runs IDLE/RUN/DONE with start > stop > tick priority.
module countdown_timer_bank
    import countdown_timer_bank_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEF,
    parameter int TICK_HZ  = TICK_HZ_DEF,
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] value,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS-1:0]       reload,
    output logic                      tick,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expired
);

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_state_e     state;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] load;

        assign load = value[i*WIDTH +: WIDTH];

        always_ff @(posedge clock) begin
            if (reset) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                shadow     <= '0;
                busy[i]    <= 1'b0;
                done[i]    <= 1'b0;
                expired[i] <= 1'b0;
            end else begin
                expired[i] <= 1'b0;
                if (start[i]) begin
                    cnt    <= load;
                    shadow <= load;
                    if (load == '0) begin
                        state      <= ST_DONE;
                        busy[i]    <= 1'b0;
                        done[i]    <= 1'b1;
                        expired[i] <= 1'b1;
                    end else begin
                        state   <= ST_RUN;
                        busy[i] <= 1'b1;
                        done[i] <= 1'b0;
                    end
                end else if (stop[i]) begin
                    cnt     <= '0;
                    state   <= ST_IDLE;
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end else if (state == ST_RUN && tick && !hold[i]) begin
                    if (cnt > WIDTH'(1)) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // reload is sampled here, at the expiry itself
                        expired[i] <= 1'b1;
                        if (reload[i]) begin
                            cnt <= shadow;
                        end else begin
                            cnt     <= '0;
                            state   <= ST_DONE;
                            busy[i] <= 1'b0;
                            done[i] <= 1'b1;
                        end
                    end
                end
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt;
    end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed self-checking bench for countdown_timer_bank.
// DIV = 10, WIDTH = 5, two channels.
module tb_countdown_timer_bank;

    localparam int W  = 5;
    localparam int CH = 2;

    logic            clock;
    logic            reset;
    logic [CH*W-1:0] value;
    logic [CH-1:0]   start;
    logic [CH-1:0]   stop;
    logic [CH-1:0]   hold;
    logic [CH-1:0]   reload;
    logic            tick;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic [CH-1:0]   expired;

    int tests;
    int fails;

    countdown_timer_bank #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .WIDTH   (W),
        .CHANNELS(CH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .value  (value),
        .start  (start),
        .stop   (stop),
        .hold   (hold),
        .reload (reload),
        .tick   (tick),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .expired(expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] cnt_of(input int ch);
        return count[ch*W +: W];
    endfunction

    // Leaves the bench in the cycle where tick is high.
    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 25) begin
            step();
            n++;
        end
        tests++;
        if (tick !== 1'b1) begin
            fails++;
            $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
        end
    endtask

    task automatic tick_step();
        wait_tick();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (tick !== 1'b0 || count !== '0 || busy !== '0 || done !== '0 || expired !== '0) begin
            fails++;
            $display("FAIL reset_outputs: tick=%b count=%h busy=%b done=%b expired=%b, required all 0",
                     tick, count, busy, done, expired);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests++;
            if (tick !== 1'b0) begin
                fails++;
                $display("FAIL reset_early_tick: edge %0d tick=%b, required 0", k, tick);
            end
        end
        step();
        tests++;
        if (tick !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_tick: tick=%b, required 1", tick);
        end
        step();
        tests++;
        if (tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: tick=%b, required 0", tick);
        end
        repeat (8) step();
        step();
        tests++;
        if (tick !== 1'b1) begin
            fails++;
            $display("FAIL tick_period: tick=%b, required 1", tick);
        end
    endtask

    task automatic test_one_shot();
        value[0 +: W] = 5'd3;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        tests++;
        if (cnt_of(0) !== 5'd3 || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL one_shot_load: count=%0d busy=%b, required 3 1", cnt_of(0), busy[0]);
        end
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd2 || expired[0] !== 1'b0) begin
            fails++;
            $display("FAIL one_shot_t1: count=%0d expired=%b, required 2 0", cnt_of(0), expired[0]);
        end
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd1) begin
            fails++;
            $display("FAIL one_shot_t2: count=%0d, required 1", cnt_of(0));
        end
        tick_step();
        tests++;
        if (expired[0] !== 1'b1 || done[0] !== 1'b1 || busy[0] !== 1'b0 || cnt_of(0) !== 5'd0) begin
            fails++;
            $display("FAIL one_shot_expire: expired=%b done=%b busy=%b count=%0d, required 1 1 0 0",
                     expired[0], done[0], busy[0], cnt_of(0));
        end
        step();
        tests++;
        if (expired[0] !== 1'b0 || done[0] !== 1'b1) begin
            fails++;
            $display("FAIL one_shot_after: expired=%b done=%b, required 0 1", expired[0], done[0]);
        end
        tick_step();
        tick_step();
        tests++;
        if (done[0] !== 1'b1 || cnt_of(0) !== 5'd0 || expired[0] !== 1'b0) begin
            fails++;
            $display("FAIL done_hold: done=%b count=%0d expired=%b, required 1 0 0",
                     done[0], cnt_of(0), expired[0]);
        end
    endtask

    task automatic test_auto_reload();
        reload[1] = 1'b1;
        value[W +: W] = 5'd2;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        tests++;
        if (cnt_of(1) !== 5'd2 || busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL reload_load: count=%0d busy=%b, required 2 1", cnt_of(1), busy[1]);
        end
        for (int r = 0; r < 2; r++) begin
            tick_step();
            tests++;
            if (cnt_of(1) !== 5'd1 || expired[1] !== 1'b0) begin
                fails++;
                $display("FAIL reload_mid: round %0d count=%0d expired=%b, required 1 0",
                         r, cnt_of(1), expired[1]);
            end
            tick_step();
            tests++;
            if (cnt_of(1) !== 5'd2 || expired[1] !== 1'b1 || busy[1] !== 1'b1 || done[1] !== 1'b0) begin
                fails++;
                $display("FAIL reload_wrap: round %0d count=%0d expired=%b busy=%b done=%b, required 2 1 1 0",
                         r, cnt_of(1), expired[1], busy[1], done[1]);
            end
        end
        reload[1] = 1'b0;
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        tests++;
        if (busy[1] !== 1'b0 || cnt_of(1) !== 5'd0) begin
            fails++;
            $display("FAIL reload_stop: busy=%b count=%0d, required 0 0", busy[1], cnt_of(1));
        end
    endtask

    task automatic test_zero_load();
        value[0 +: W] = 5'd0;
        reload[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        reload[0] = 1'b0;
        tests++;
        if (done[0] !== 1'b1 || expired[0] !== 1'b1 || cnt_of(0) !== 5'd0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL zero_load: done=%b expired=%b count=%0d busy=%b, required 1 1 0 0",
                     done[0], expired[0], cnt_of(0), busy[0]);
        end
        step();
        tests++;
        if (expired[0] !== 1'b0 || done[0] !== 1'b1) begin
            fails++;
            $display("FAIL zero_load_after: expired=%b done=%b, required 0 1", expired[0], done[0]);
        end
    endtask

    task automatic test_hold_stop();
        int seen;
        value[0 +: W] = 5'd5;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        hold[0] = 1'b1;
        tick_step();
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd5 || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL hold_freeze: count=%0d busy=%b, required 5 1", cnt_of(0), busy[0]);
        end
        hold[0] = 1'b0;
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd4) begin
            fails++;
            $display("FAIL hold_release: count=%0d, required 4", cnt_of(0));
        end
        tick_step();
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd2) begin
            fails++;
            $display("FAIL pre_stop: count=%0d, required 2", cnt_of(0));
        end
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        seen = expired[0];
        tests++;
        if (cnt_of(0) !== 5'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            fails++;
            $display("FAIL stop_idle: count=%0d busy=%b done=%b, required 0 0 0",
                     cnt_of(0), busy[0], done[0]);
        end
        for (int k = 0; k < 25; k++) begin
            step();
            seen = seen | int'(expired[0]);
        end
        tests++;
        if (seen != 0 || cnt_of(0) !== 5'd0) begin
            fails++;
            $display("FAIL stop_no_expire: expired_seen=%0d count=%0d, required 0 0", seen, cnt_of(0));
        end
    endtask

    task automatic test_collisions();
        value[0 +: W] = 5'd4;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        tick_step();
        tests++;
        if (cnt_of(0) !== 5'd3) begin
            fails++;
            $display("FAIL coll_pre: count=%0d, required 3", cnt_of(0));
        end
        wait_tick();
        value[0 +: W] = 5'd7;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        tests++;
        if (cnt_of(0) !== 5'd7) begin
            fails++;
            $display("FAIL start_on_tick: count=%0d, required 7", cnt_of(0));
        end
        value[0 +: W] = 5'd6;
        start[0] = 1'b1;
        stop[0] = 1'b1;
        step();
        start[0] = 1'b0;
        stop[0] = 1'b0;
        tests++;
        if (cnt_of(0) !== 5'd6 || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL start_beats_stop: count=%0d busy=%b, required 6 1", cnt_of(0), busy[0]);
        end
        value = {5'd1, 5'd1};
        start = 2'b11;
        step();
        start = 2'b00;
        tick_step();
        tests++;
        if (expired !== 2'b11 || done !== 2'b11) begin
            fails++;
            $display("FAIL simultaneous_expiry: expired=%b done=%b, required 11 11", expired, done);
        end
        value = {5'd9, 5'd3};
        start = 2'b11;
        step();
        start = 2'b00;
        tick_step();
        reset = 1'b1;
        step();
        tests++;
        if (count !== '0 || busy !== '0 || done !== '0 || expired !== '0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: count=%h busy=%b done=%b expired=%b tick=%b, required all 0",
                     count, busy, done, expired, tick);
        end
        repeat (12) step();
        reset = 1'b0;
        repeat (30) step();
        tests++;
        if (expired !== '0 || busy !== '0 || count !== '0) begin
            fails++;
            $display("FAIL reset_stays_idle: expired=%b busy=%b count=%h, required 0 0 0",
                     expired, busy, count);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        value  = '0;
        start  = '0;
        stop   = '0;
        hold   = '0;
        reload = '0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_zero_load();
        test_hold_stop();
        test_collisions();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bank.md
# countdown_timer_bank

Multi-channel, parametrised countdown timer bank driven by one shared prescaled tick. It succeeds the single-channel 5-bit, 1 Hz timer and provides:
- N independent channels, each with its own start, hold, stop and auto-reload control.
- Configurable tick rate and counter width.
- Registered expiry pulses and status.

It sits between the phase controller FSMs and the display logic. It supplies phase timeouts and the display refresh tick.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1, countdown tick rate; DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2
- WIDTH, 5, count width per channel
- CHANNELS, 2, number of independent channels
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high; clock clock
- value  input  CHANNELS*WIDTH  load value per channel; channel i uses bits [i*WIDTH +: WIDTH]
- start  input  CHANNELS  load value[i] and run
- stop  input  CHANNELS  abort to idle
- hold  input  CHANNELS  freeze count while high
- reload  input  CHANNELS  1 = auto-reload on expiry, 0 = one-shot
- tick  output  1  one-cycle pulse at TICK_HZ (one_hz_enable equivalent)
- count  output  CHANNELS*WIDTH  current remaining ticks
- busy  output  CHANNELS  channel in RUN
- done  output  CHANNELS  level, channel in DONE
- expired  output  CHANNELS  one-cycle pulse per expiry

## Operation
- Prescaler:
  - Free-running counter 0..DIV-1, running from reset.
  - tick = 1 in exactly the cycle where the counter equals DIV-1; the counter wraps to 0 the next cycle.
- Per-channel FSM states: IDLE, RUN, DONE.
- In every state, channel priority is: start > stop > tick.
- start[i], any state:
  - count <= value[i]; reload value latched into shadow register; state <= RUN.
  - If value[i] == 0: state <= DONE directly, expired[i] pulses, and the reload bit is ignored.
- stop[i], no start: count <= 0, state <= IDLE, no expired pulse.
- RUN, tick = 1, hold[i] = 0:
  - count > 1: count <= count - 1.
  - count == 1: expired[i] pulses.
    - reload[i] = 1: count <= shadow, stay RUN.
    - reload[i] = 0: count <= 0, state <= DONE.
- hold[i] = 1: ticks ignored; the tick is lost, not deferred.
- DONE is held until start or stop. IDLE and DONE ignore ticks.
- reload[i] is sampled at the expiry cycle, not at start.
- Arithmetic is unsigned WIDTH-bit. Count never decrements below 0, so there is no wrap-around.

## Timing
- All outputs are registered and reflect inputs sampled on the previous rising edge.
- Reset values: prescaler = 0, tick = 0, all count = 0, busy = 0, done = 0, expired = 0, all channels IDLE.
- Reset mid-count aborts every channel without an expired pulse.
- start sampled at edge k: count = value and busy = 1 from cycle k+1.
- With tick at cycle t and count == 1: expired = 1 during cycle t+1 only. done = 1 from t+1 for one-shot; count = shadow at t+1 for reload.
- Expiry latency from start with value V: between (V-1)·DIV+1 and V·DIV cycles, depending on prescaler phase. start does not resynchronise the prescaler.
- start and tick in the same cycle: start wins and the tick is not applied.
- Channels are fully independent. Simultaneous expiries on several channels pulse in the same cycle.

## Structure
- Shared package holds:
  - State encodings: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Default CLK_HZ and TICK_HZ constants.
  - A clog2 helper for sizing the prescaler, width clog2(DIV).
- Sub-module tick_prescaler(clock, reset, tick), parameters CLK_HZ and TICK_HZ. It is instantiated once and shared by all channels.
- The channel logic sits in a generate loop inside countdown_timer_bank. No per-channel sub-module is needed.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=5, CHANNELS=2.
- Reset: assert reset for 3 cycles -> all outputs 0; first tick occurs 10 cycles after reset release.
- One-shot: start[0] with value=3 -> count 3,2,1 on successive ticks; expired[0] high one cycle on the third tick; done[0]=1, busy[0]=0, count=0.
- Auto-reload: reload[1]=1, start[1] with value=2 -> expired[1] pulses every 2 ticks; count sequence 2,1,2,1; busy stays 1.
- Zero load: start[0] with value=0 -> next cycle done[0]=1, expired[0] pulses once, count=0.
- Hold and stop: hold[0]=1 across 2 ticks -> count unchanged. stop[0] at count=2 -> IDLE, count=0, no expired pulse.
- Collisions:
  - start[0] in the tick cycle -> count = new value, no decrement.
  - start and stop together -> start wins.
  - Reset during RUN -> all channels clear, no expired pulse.
